// File: rtl/ascon128_decrypt_core.sv
// Ascon-128 decryption core: init, AD absorb, CT decrypt with plaintext streaming,
// finalization and tag check. One permutation round is applied per clock.
module ascon128_decrypt_core #(
  parameter logic [63:0] IV       = 64'h80400c0600000000,
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic         ad_present_i,
  input  logic [63:0]  data_i,
  input  logic         data_valid_i,
  input  logic         data_last_i,
  input  logic [2:0]   data_bytes_i,
  output logic         data_ready_o,
  input  logic [127:0] tag_i,
  output logic [63:0]  plain_o,
  output logic         plain_valid_o,
  output logic [3:0]   plain_bytes_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         tag_ok_o
);

  // Round counter start values; every permutation ends on round 11.
  localparam logic [3:0] CtrA = 4'(12 - ROUNDS_A);
  localparam logic [3:0] CtrB = 4'(12 - ROUNDS_B);

  typedef enum logic [3:0] {
    StIdle, StInit, StAdWait, StAdPerm, StCtWait, StCtPerm, StFinal, StTag, StDone
  } state_e;

  state_e       state;
  logic [63:0]  x0, x1, x2, x3, x4;
  logic [3:0]   round_ctr;
  logic [63:0]  key_hi, key_lo;
  logic [127:0] tag_ref;
  logic         ad_flag;
  logic         ad_last;

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;
  logic [63:0] rnd0, rnd1, rnd2, rnd3, rnd4;
  logic [63:0] ct_mask, ct_pad;
  logic        last_round;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One Ascon round on the current state: constant add, bitsliced S-box, linear layer.
  assign a0 = x0 ^ x4;
  assign a1 = x1;
  assign a2 = x2 ^ {56'h0, ~round_ctr, round_ctr} ^ x1;
  assign a3 = x3;
  assign a4 = x4 ^ x3;
  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);
  assign c0 = b0 ^ b4;
  assign c1 = b1 ^ b0;
  assign c2 = ~b2;
  assign c3 = b3 ^ b2;
  assign c4 = b4;
  assign rnd0 = c0 ^ rotr(c0, 19) ^ rotr(c0, 28);
  assign rnd1 = c1 ^ rotr(c1, 61) ^ rotr(c1, 39);
  assign rnd2 = c2 ^ rotr(c2, 1) ^ rotr(c2, 6);
  assign rnd3 = c3 ^ rotr(c3, 10) ^ rotr(c3, 17);
  assign rnd4 = c4 ^ rotr(c4, 7) ^ rotr(c4, 41);

  assign last_round = (round_ctr == 4'd11);

  // Last CT block: top n bytes are data, padding byte sits right after them.
  assign ct_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {data_bytes_i, 3'b000});
  assign ct_pad  = 64'h8000_0000_0000_0000 >> {data_bytes_i, 3'b000};

  assign data_ready_o = (state == StAdWait) || (state == StCtWait);

  // Control FSM, sponge state and registered outputs.
  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      state         <= StIdle;
      x0            <= '0;
      x1            <= '0;
      x2            <= '0;
      x3            <= '0;
      x4            <= '0;
      round_ctr     <= '0;
      key_hi        <= '0;
      key_lo        <= '0;
      tag_ref       <= '0;
      ad_flag       <= 1'b0;
      ad_last       <= 1'b0;
      plain_o       <= '0;
      plain_valid_o <= 1'b0;
      plain_bytes_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      tag_ok_o      <= 1'b0;
    end else begin
      plain_valid_o <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          if (start_i) begin
            {x0, x1, x2, x3, x4} <= {IV, key_i, nonce_i};
            {key_hi, key_lo}     <= key_i;
            ad_flag              <= ad_present_i;
            round_ctr            <= CtrA;
            busy_o               <= 1'b1;
            done_o               <= 1'b0;
            tag_ok_o             <= 1'b0;
            state                <= StInit;
          end
        end
        StInit: begin
          {x0, x1, x2, x3, x4} <= {rnd0, rnd1, rnd2, rnd3, rnd4};
          round_ctr            <= round_ctr + 4'd1;
          if (last_round) begin
            x3 <= rnd3 ^ key_hi;
            if (ad_flag) begin
              x4    <= rnd4 ^ key_lo;
              state <= StAdWait;
            end else begin
              // No AD: domain separation bit goes in straight away.
              x4    <= rnd4 ^ key_lo ^ 64'd1;
              state <= StCtWait;
            end
          end
        end
        StAdWait: begin
          if (data_valid_i) begin
            x0        <= x0 ^ data_i;
            ad_last   <= data_last_i;
            round_ctr <= CtrB;
            state     <= StAdPerm;
          end
        end
        StAdPerm: begin
          {x0, x1, x2, x3, x4} <= {rnd0, rnd1, rnd2, rnd3, rnd4};
          round_ctr            <= round_ctr + 4'd1;
          if (last_round) begin
            if (ad_last) begin
              x4    <= rnd4 ^ 64'd1;
              state <= StCtWait;
            end else begin
              state <= StAdWait;
            end
          end
        end
        StCtWait: begin
          if (data_valid_i) begin
            if (!data_last_i) begin
              plain_o       <= x0 ^ data_i;
              plain_valid_o <= 1'b1;
              plain_bytes_o <= 4'd8;
              x0            <= data_i;
              round_ctr     <= CtrB;
              state         <= StCtPerm;
            end else begin
              // Partial block: no permutation, go straight to finalization.
              plain_o       <= (x0 ^ data_i) & ct_mask;
              plain_valid_o <= |data_bytes_i;
              plain_bytes_o <= {1'b0, data_bytes_i};
              x0            <= ((data_i & ct_mask) | (x0 & ~ct_mask)) ^ ct_pad;
              x1            <= x1 ^ key_hi;
              x2            <= x2 ^ key_lo;
              tag_ref       <= tag_i;
              round_ctr     <= CtrA;
              state         <= StFinal;
            end
          end
        end
        StCtPerm: begin
          {x0, x1, x2, x3, x4} <= {rnd0, rnd1, rnd2, rnd3, rnd4};
          round_ctr            <= round_ctr + 4'd1;
          if (last_round) state <= StCtWait;
        end
        StFinal: begin
          {x0, x1, x2, x3, x4} <= {rnd0, rnd1, rnd2, rnd3, rnd4};
          round_ctr            <= round_ctr + 4'd1;
          if (last_round) state <= StTag;
        end
        StTag: begin
          tag_ok_o <= ({x3 ^ key_hi, x4 ^ key_lo} == tag_ref);
          done_o   <= 1'b1;
          busy_o   <= 1'b0;
          state    <= StDone;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon128_decrypt_core.sv
// Directed bench for ascon128_decrypt_core with a table-driven Ascon-128 encrypt model.
module tb_ascon128_decrypt_core;

  localparam logic [63:0]  TB_IV   = 64'h80400c0600000000;
  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KAT_TAG = 128'hE355159F292911F794CB1432A0103A8A;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic         clk = 1'b0;
  logic         resetb = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] nonce = '0;
  logic         ad_present = 1'b0;
  logic [63:0]  data = '0;
  logic         data_valid = 1'b0;
  logic         data_last = 1'b0;
  logic [2:0]   data_bytes = '0;
  logic         data_ready;
  logic [127:0] tag_in = '0;
  logic [63:0]  plain;
  logic         plain_valid;
  logic [3:0]   plain_bytes;
  logic         busy;
  logic         done;
  logic         tag_ok;

  int n_tests = 0;
  int n_fail  = 0;

  ascon128_decrypt_core dut (
    .clock_i      (clk),
    .resetb_i     (resetb),
    .start_i      (start),
    .key_i        (key),
    .nonce_i      (nonce),
    .ad_present_i (ad_present),
    .data_i       (data),
    .data_valid_i (data_valid),
    .data_last_i  (data_last),
    .data_bytes_i (data_bytes),
    .data_ready_o (data_ready),
    .tag_i        (tag_in),
    .plain_o      (plain),
    .plain_valid_o(plain_valid),
    .plain_bytes_o(plain_bytes),
    .busy_o       (busy),
    .done_o       (done),
    .tag_ok_o     (tag_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] tb_round(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  sb;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    x[2] = x[2] ^ {56'h0, 8'((15 - r) * 16 + r)};
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      sb  = SBOX[col];
      for (int i = 0; i < 5; i++) y[i][b] = sb[4 - i];
    end
    y[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
    y[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
    y[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
    y[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
    y[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
    return {y[0], y[1], y[2], y[3], y[4]};
  endfunction

  function automatic logic [319:0] tb_perm(input logic [319:0] s, input int n);
    logic [319:0] t;
    t = s;
    for (int r = 12 - n; r < 12; r++) t = tb_round(t, r);
    return t;
  endfunction

  logic [127:0] m_key, m_nonce, m_tag;
  logic [63:0]  m_ad [2];
  logic [63:0]  m_pt [2];
  logic [63:0]  m_ct [2];
  logic [63:0]  m_last_pt, m_ct_last;
  int           m_nad, m_nfull, m_last_n;

  task automatic model_enc();
    logic [319:0] s;
    logic [63:0]  mask, pad;
    s = tb_perm({TB_IV, m_key, m_nonce}, 12);
    s[127:0] = s[127:0] ^ m_key;
    for (int i = 0; i < m_nad; i++) begin
      s[319:256] = s[319:256] ^ m_ad[i];
      s = tb_perm(s, 6);
    end
    s[0] = ~s[0];
    for (int i = 0; i < m_nfull; i++) begin
      s[319:256] = s[319:256] ^ m_pt[i];
      m_ct[i] = s[319:256];
      s = tb_perm(s, 6);
    end
    mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> (8 * m_last_n));
    pad  = 64'h8000_0000_0000_0000 >> (8 * m_last_n);
    m_ct_last  = (s[319:256] ^ m_last_pt) & mask;
    s[319:256] = s[319:256] ^ (m_last_pt & mask) ^ pad;
    s[255:128] = s[255:128] ^ m_key;
    s = tb_perm(s, 12);
    m_tag = s[127:0] ^ m_key;
  endtask

  // ---------------- stimulus helpers (called on a falling edge) ----------------
  task automatic do_start(input logic [127:0] k, input logic [127:0] n, input logic adp);
    start = 1'b1; key = k; nonce = n; ad_present = adp;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, input logic [2:0] nb,
                           input logic [127:0] tg, output logic pv, output logic [63:0] pl,
                           output logic [3:0] pb);
    int waited;
    waited = 0;
    data = d; data_last = last; data_bytes = nb; tag_in = tg; data_valid = 1'b1;
    while (!data_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("beat_ready_timeout", 128'(waited < 100), 128'd1);
    @(negedge clk);
    data_valid = 1'b0;
    pv = plain_valid; pl = plain; pb = plain_bytes;
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("done_timeout", 128'(done), 128'd1);
  endtask

  // Empty AD, empty CT under the KAT key/nonce; data_valid held high from start.
  task automatic run_empty(input logic [127:0] tg, output int cyc, output logic rdy_early,
                           output logic rdy13, output logic pv_seen);
    cyc = 0; rdy_early = 1'b0; rdy13 = 1'b0; pv_seen = 1'b0;
    key = KAT_KEY; nonce = KAT_KEY; ad_present = 1'b0;
    data = '0; data_last = 1'b1; data_bytes = 3'd0; tag_in = tg; data_valid = 1'b1;
    start = 1'b1;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc <= 12) rdy_early = rdy_early | data_ready;
      if (cyc == 13) rdy13 = data_ready;
      pv_seen = pv_seen | plain_valid;
      if (done) break;
    end
    data_valid = 1'b0;
  endtask

  int          cyc;
  logic        rdy_early, rdy13, pv_seen, rdy_any;
  logic        pv;
  logic [63:0] pl;
  logic [3:0]  pb;

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    check("reset_outputs", {plain, plain_valid, plain_bytes, busy, done, tag_ok, data_ready}, '0);
    resetb = 1'b0;
    @(negedge clk);

    // Test 1: KAT, no AD, empty CT
    run_empty(KAT_TAG, cyc, rdy_early, rdy13, pv_seen);
    check("t1_latency", cyc, 27);
    check("t1_ready_in_init", rdy_early, 0);
    check("t1_ready_ct_wait", rdy13, 1);
    check("t1_no_plain_valid", pv_seen, 0);
    check("t1_tag_ok", tag_ok, 1);
    check("t1_busy_clear", busy, 0);

    // Test 2: flipped tag, restarted from DONE
    run_empty(KAT_TAG ^ 128'd1, cyc, rdy_early, rdy13, pv_seen);
    check("t2_done", done, 1);
    check("t2_tag_bad", tag_ok, 0);

    // Test 3 (+6): round trip with AD; valid held through INIT/AD_PERM, start while busy
    m_key = 128'h8899AABBCCDDEEFF0011223344556677;
    m_nonce = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    m_nad = 1; m_ad[0] = 64'h4153434F4E800000;
    m_nfull = 1; m_pt[0] = 64'h3230323380000000;
    m_last_n = 0; m_last_pt = '0;
    model_enc();
    data = m_ad[0]; data_last = 1'b1; data_valid = 1'b1;
    do_start(m_key, m_nonce, 1'b1);
    check("t3_busy", busy, 1);
    send_beat(m_ad[0], 1'b1, 3'd0, '0, pv, pl, pb);
    data = m_ct[0]; data_last = 1'b0; data_valid = 1'b1;
    rdy_any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rdy_any = rdy_any | data_ready;
      start = (i == 2);
      if (i == 2) key = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
      @(negedge clk);
    end
    start = 1'b0;
    check("t6_ready_low_ad_perm", rdy_any, 0);
    check("t6_ad_perm_6_cycles", data_ready, 1);
    check("t6_start_ignored_busy", {busy, done}, 2'b10);
    send_beat(m_ct[0], 1'b0, 3'd0, '0, pv, pl, pb);
    check("t3_plain", pl, 64'h3230323380000000);
    check("t3_plain_valid", pv, 1);
    check("t3_plain_bytes", pb, 8);
    send_beat(64'h0, 1'b1, 3'd0, m_tag, pv, pl, pb);
    check("t3_last_no_valid", pv, 0);
    wait_done();
    check("t3_tag_ok", tag_ok, 1);

    // Test 4: partial last block, n=3, garbage in ignored low bytes
    m_key = 128'h0123456789ABCDEFFEDCBA9876543210;
    m_nonce = 128'h00112233445566778899AABBCCDDEEFF;
    m_nad = 0; m_nfull = 1; m_pt[0] = 64'h0011223344556677;
    m_last_n = 3; m_last_pt = 64'hA1B2C30000000000;
    model_enc();
    do_start(m_key, m_nonce, 1'b0);
    send_beat(m_ct[0], 1'b0, 3'd0, '0, pv, pl, pb);
    check("t4_plain0", pl, 64'h0011223344556677);
    send_beat(m_ct_last | 64'h000000DEADBEEF55, 1'b1, 3'd3, m_tag, pv, pl, pb);
    check("t4_plain_last", pl, 64'hA1B2C30000000000);
    check("t4_low_bytes_zero", pl[39:0], 0);
    check("t4_plain_bytes", pb, 3);
    check("t4_plain_valid", pv, 1);
    wait_done();
    check("t4_tag_ok", tag_ok, 1);

    // Test 5: reset during CT_PERM, then a clean KAT run
    do_start(m_key, m_nonce, 1'b0);
    send_beat(m_ct[0], 1'b0, 3'd0, '0, pv, pl, pb);
    @(negedge clk);
    check("t5_busy_before_reset", busy, 1);
    resetb = 1'b1;
    @(negedge clk);
    resetb = 1'b0;
    check("t5_outputs_zero",
          {plain, plain_valid, plain_bytes, busy, done, tag_ok, data_ready}, '0);
    @(negedge clk);
    check("t5_stays_idle", {busy, data_ready}, 0);
    run_empty(KAT_TAG, cyc, rdy_early, rdy13, pv_seen);
    check("t5_rerun_latency", cyc, 27);
    check("t5_rerun_tag_ok", tag_ok, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
